// File: rtl/lsu_mem_access.sv
// Load/store execute-memory stage: effective address, single valid/ready request, load align/extend.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_CHK_EN.
module lsu_mem_access #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            is_load_in,
  input  logic            zero_ext_in,
  input  logic            is_nop_in,
  input  logic [1:0]      size_in,
  input  logic [4:0]      rd_in,
  input  logic [11:0]     imm_in,
  input  logic [XLEN-1:0] rs1_val_in,
  input  logic [XLEN-1:0] rs2_val_in,
  output logic            stall_out,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_we,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [3:0]      mem_req_be,
  output logic [XLEN-1:0] mem_req_wdata,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            store_done,
  output logic            misalign_err
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("lsu_mem_access: only XLEN = 32 is supported");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_nxt;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] size, input logic [XLEN-1:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extract(input logic [1:0] size, input logic [1:0] off,
                                                   input logic zext, input logic [XLEN-1:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*off +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   return zext ? {{(XLEN-8){1'b0}}, b}  : {{(XLEN-8){b[7]}}, b};
      2'b01:   return zext ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

  // Stage p0: operand decode and effective address, valid only while IDLE
  logic signed [XLEN-1:0] imm_sext_p0;
  logic [XLEN-1:0]        ea_p0;
  logic [XLEN-1:0]        addr_p0;
  logic                   mis_p0;
  logic                   accept_p0;

  assign imm_sext_p0 = {{(XLEN-12){imm_in[11]}}, imm_in};
  assign ea_p0       = rs1_val_in + imm_sext_p0;
  assign accept_p0   = (state == IDLE) && !is_nop_in;

`ifdef LSU_MISALIGN_CHK_EN
  assign mis_p0  = ((size_in == 2'b01) && ea_p0[0]) || (size_in[1] && (ea_p0[1:0] != 2'b00));
  assign addr_p0 = ea_p0;
`else
  assign mis_p0  = 1'b0;
  always_comb begin
    addr_p0 = ea_p0;
    if (size_in == 2'b01) addr_p0[0]   = 1'b0;
    else if (size_in[1])  addr_p0[1:0] = 2'b00;
  end
`endif

  // Stage p1: operation latched on accept, held until DONE
  logic       is_load_p1;
  logic       zext_p1;
  logic [1:0] size_p1;
  logic       mis_p1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_load_p1    <= 1'b0;
      zext_p1       <= 1'b0;
      size_p1       <= 2'b00;
      mis_p1        <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_be    <= 4'b0000;
      mem_req_wdata <= '0;
      wb_rd         <= 5'd0;
      wb_data       <= '0;
    end else begin
      if (accept_p0) begin
        is_load_p1    <= is_load_in;
        zext_p1       <= zero_ext_in;
        size_p1       <= size_in;
        mis_p1        <= mis_p0;
        mem_req_we    <= !is_load_in;
        mem_req_addr  <= addr_p0;
        mem_req_be    <= lane_be(size_in, addr_p0[1:0]);
        mem_req_wdata <= lane_wdata(size_in, rs2_val_in);
        wb_rd         <= rd_in;
      end
      // Stage p2: response captured only while waiting on our own request
      if ((state == WAIT) && mem_rsp_valid)
        wb_data <= load_extract(size_p1, mem_req_addr[1:0], zext_p1, mem_rsp_rdata);
    end
  end

  always_comb begin
    state_nxt     = state;
    stall_out     = 1'b0;
    mem_req_valid = 1'b0;
    wb_valid      = 1'b0;
    store_done    = 1'b0;
    misalign_err  = 1'b0;
    case (state)
      IDLE: begin
        if (!is_nop_in) begin
          stall_out = 1'b1;
          state_nxt = mis_p0 ? DONE : REQ;
        end
      end
      REQ: begin
        stall_out     = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = is_load_p1 ? WAIT : DONE;
      end
      WAIT: begin
        stall_out = 1'b1;
        if (mem_rsp_valid) state_nxt = DONE;
      end
      DONE: begin
        state_nxt    = IDLE;
        wb_valid     = is_load_p1 && !mis_p1 && (wb_rd != 5'd0);
        store_done   = !is_load_p1 && !mis_p1;
        misalign_err = mis_p1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Testbench for lsu_mem_access: directed vector table, reset corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_lsu_mem_access;

`ifdef LSU_MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        is_load_in, zero_ext_in, is_nop_in;
  logic [1:0]  size_in;
  logic [4:0]  rd_in;
  logic [11:0] imm_in;
  logic [31:0] rs1_val_in, rs2_val_in;
  logic        stall_out, mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        wb_valid, store_done, misalign_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  lsu_mem_access #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .is_load_in(is_load_in), .zero_ext_in(zero_ext_in), .is_nop_in(is_nop_in),
    .size_in(size_in), .rd_in(rd_in), .imm_in(imm_in),
    .rs1_val_in(rs1_val_in), .rs2_val_in(rs2_val_in),
    .stall_out(stall_out), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_be(mem_req_be),
    .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .store_done(store_done), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_load;
    logic        zext;
    logic [1:0]  size;
    logic [4:0]  rd;
    logic [11:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          rdy_dly;
    int          rsp_dly;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_wb;
    logic        e_wbv;
    logic        e_mis;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t hand(input logic ld, input logic zx, input logic [1:0] sz, input logic [4:0] rd,
                                input logic [11:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] rdata, input int rdy, input int rsp,
                                input logic [31:0] ea, input logic [3:0] be, input logic [31:0] wd,
                                input logic [31:0] wb, input logic wbv, input logic mis);
    vec_t v;
    v.is_load = ld; v.zext = zx; v.size = sz; v.rd = rd; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2;
    v.rdata = rdata; v.rdy_dly = rdy; v.rsp_dly = rsp;
    v.e_addr = ea; v.e_be = be; v.e_wdata = wd; v.e_wb = wb; v.e_wbv = wbv; v.e_mis = mis;
    return v;
  endfunction

  // Reference: byte-count arithmetic on the effective address and data words.
  function automatic vec_t model(input vec_t v);
    vec_t   r;
    longint imm_s, ea, val, lim;
    int     nb, lane;
    r = v;
    imm_s = v.imm[11] ? longint'(v.imm) - 4096 : longint'(v.imm);
    ea = (longint'(v.rs1) + imm_s) & 64'hFFFF_FFFF;
    nb = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    r.e_mis = CHK_EN && (ea % nb != 0);
    if (!CHK_EN) ea = ea - (ea % nb);
    lane = int'(ea % 4);
    r.e_addr = ea[31:0];
    r.e_be = 4'(((1 << nb) - 1) << lane);
    case (nb)
      1:       r.e_wdata = {24'd0, v.rs2[7:0]} * 32'h0101_0101;
      2:       r.e_wdata = {16'd0, v.rs2[15:0]} * 32'h0001_0001;
      default: r.e_wdata = v.rs2;
    endcase
    if (nb == 4) begin
      r.e_wb = v.rdata;
    end else begin
      lim = longint'(1) << (8 * nb);
      val = longint'(v.rdata >> (8 * lane)) % lim;
      if (!v.zext && val >= lim / 2) val = val - lim;
      r.e_wb = val[31:0];
    end
    r.e_wbv = v.is_load && (v.rd != 5'd0) && !r.e_mis;
    return r;
  endfunction

  task automatic idle_inputs();
    is_nop_in   = 1'b1;
    is_load_in  = 1'($urandom);
    zero_ext_in = 1'($urandom);
    size_in     = 2'($urandom);
    rd_in       = 5'($urandom);
    imm_in      = 12'($urandom);
    rs1_val_in  = $urandom;
    rs2_val_in  = $urandom;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = $urandom;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " req_valid"}, {31'd0, mem_req_valid}, 32'd0);
    chk({tag, " stall"}, {31'd0, stall_out}, 32'd0);
    chk({tag, " strobes"}, {29'd0, wb_valid, store_done, misalign_err}, 32'd0);
    chk({tag, " addr"}, mem_req_addr, 32'd0);
    chk({tag, " be_we"}, {27'd0, mem_req_we, mem_req_be}, 32'd0);
    chk({tag, " wdata"}, mem_req_wdata, 32'd0);
    chk({tag, " wb_rd"}, {27'd0, wb_rd}, 32'd0);
    chk({tag, " wb_data"}, wb_data, 32'd0);
  endtask

  // Entered and left at 1 time unit after a rising edge with the unit in IDLE.
  task automatic run_op(input vec_t v, input string tag);
    is_nop_in = 1'b0; is_load_in = v.is_load; zero_ext_in = v.zext; size_in = v.size;
    rd_in = v.rd; imm_in = v.imm; rs1_val_in = v.rs1; rs2_val_in = v.rs2;
    #1;
    chk({tag, " accept stall"}, {31'd0, stall_out}, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    if (!v.e_mis) begin
      for (int i = 0; i <= v.rdy_dly; i++) begin
        mem_req_ready = (i == v.rdy_dly);
        mem_rsp_valid = (i != v.rdy_dly);
        #1;
        chk({tag, " req valid/stall"}, {30'd0, mem_req_valid, stall_out}, 32'd3);
        chk({tag, " req addr"}, mem_req_addr, v.e_addr);
        chk({tag, " req be/we"}, {27'd0, mem_req_we, mem_req_be}, {27'd0, !v.is_load, v.e_be});
        if (!v.is_load) chk({tag, " req wdata"}, mem_req_wdata, v.e_wdata);
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (v.is_load) begin
        for (int i = 0; i <= v.rsp_dly; i++) begin
          mem_rsp_valid = (i == v.rsp_dly);
          mem_rsp_rdata = (i == v.rsp_dly) ? v.rdata : $urandom;
          #1;
          chk({tag, " wait valid/stall"}, {30'd0, mem_req_valid, stall_out}, 32'd1);
          @(posedge clk); #1;
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = $urandom;
      end
    end
    #1;
    chk({tag, " done valid/stall"}, {30'd0, mem_req_valid, stall_out}, 32'd0);
    chk({tag, " done strobes"}, {29'd0, wb_valid, store_done, misalign_err},
        {29'd0, v.e_wbv, !v.is_load && !v.e_mis, v.e_mis});
    if (v.is_load && !v.e_mis) chk({tag, " wb_data"}, wb_data, v.e_wb);
    if (v.e_wbv) chk({tag, " wb_rd"}, {27'd0, wb_rd}, {27'd0, v.rd});
    @(posedge clk); #1;
    chk({tag, " idle strobes"}, {27'd0, wb_valid, store_done, misalign_err, mem_req_valid, stall_out}, 32'd0);
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    tbl[0] = hand(0, 0, 2'b00, 5'd0, 12'h003, 32'h1000, 32'h0000_00AB, 32'h0, 2, 0,
                  32'h1003, 4'b1000, 32'hABAB_ABAB, 32'h0, 0, 0);
    tbl[1] = hand(1, 0, 2'b01, 5'd5, 12'hFFE, 32'h2000, 32'h0, 32'h8001_1234, 0, 0,
                  32'h1FFE, 4'b1100, 32'h0, 32'hFFFF_8001, 1, 0);
    tbl[2] = hand(1, 1, 2'b01, 5'd6, 12'hFFE, 32'h2000, 32'h0, 32'h8001_1234, 0, 0,
                  32'h1FFE, 4'b1100, 32'h0, 32'h0000_8001, 1, 0);
    tbl[3] = hand(1, 0, 2'b00, 5'd0, 12'h001, 32'h3000, 32'h0, 32'h1122_3344, 0, 1,
                  32'h3001, 4'b0010, 32'h0, 32'h0000_0033, 0, 0);
    tbl[4] = hand(0, 0, 2'b01, 5'd0, 12'h002, 32'h4000, 32'h1234_ABCD, 32'h0, 1, 0,
                  32'h4002, 4'b1100, 32'hABCD_ABCD, 32'h0, 0, 0);
    tbl[5] = hand(0, 0, 2'b10, 5'd0, 12'h800, 32'h5800, 32'hDEAD_BEEF, 32'h0, 0, 0,
                  32'h5000, 4'b1111, 32'hDEAD_BEEF, 32'h0, 0, 0);
    tbl[6] = hand(1, 0, 2'b00, 5'd7, 12'hFFF, 32'h0000_0010, 32'h0, 32'h8000_0000, 1, 2,
                  32'h0000_000F, 4'b1000, 32'h0, 32'hFFFF_FF80, 1, 0);
`ifdef LSU_MISALIGN_CHK_EN
    tbl[7] = hand(1, 0, 2'b10, 5'd3, 12'h001, 32'h1000, 32'h0, 32'hCAFE_F00D, 0, 0,
                  32'h1001, 4'b1111, 32'h0, 32'h0, 0, 1);
`else
    tbl[7] = hand(1, 0, 2'b10, 5'd3, 12'h001, 32'h1000, 32'h0, 32'hCAFE_F00D, 0, 0,
                  32'h1000, 4'b1111, 32'h0, 32'hCAFE_F00D, 1, 0);
`endif
    tbl[8] = hand(1, 0, 2'b11, 5'd1, 12'h000, 32'h0000_0040, 32'h0, 32'h1234_5678, 0, 0,
                  32'h0000_0040, 4'b1111, 32'h0, 32'h1234_5678, 1, 0);

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Reset held two cycles while a request is pending.
    is_nop_in = 1'b0; is_load_in = 1'b0; size_in = 2'b10; imm_in = 12'h0; rs1_val_in = 32'h100;
    @(posedge clk); #1;
    idle_inputs();
    #1;
    chk("rst_req pending", {31'd0, mem_req_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("rst_req c1");
    @(posedge clk); #1;
    check_reset("rst_req c2");
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

    // Reset while waiting for load data; the late response must be dropped.
    is_nop_in = 1'b0; is_load_in = 1'b1; zero_ext_in = 1'b0; size_in = 2'b10;
    rd_in = 5'd9; imm_in = 12'h0; rs1_val_in = 32'h200;
    @(posedge clk); #1;
    idle_inputs();
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    #1;
    chk("rst_wait in wait", {30'd0, mem_req_valid, stall_out}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h55AA_55AA;
    #1;
    chk("rst_wait stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    chk("rst_wait late rsp", {31'd0, wb_valid}, 32'd0);
    chk("rst_wait wb_data", wb_data, 32'd0);
    @(posedge clk); #1;
    chk("rst_wait after", {29'd0, wb_valid, mem_req_valid, stall_out}, 32'd0);
    run_op(tbl[1], "post_rst");

    for (int i = 0; i < 60; i++) begin
      rv.is_load = 1'($urandom);
      rv.zext    = 1'($urandom);
      rv.size    = 2'($urandom);
      rv.rd      = 5'($urandom);
      rv.imm     = 12'($urandom);
      rv.rs1     = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FFFF);
      rv.rs2     = $urandom;
      rv.rdata   = $urandom;
      rv.rdy_dly = $urandom_range(0, 2);
      rv.rsp_dly = $urandom_range(0, 2);
      run_op(model(rv), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
